// File: rtl/spatz_perf_counter_pkg.sv
// Shared register map, control/status layouts and address helpers for the Spatz performance counter unit.
package spatz_perf_counter_pkg;

  // Word offsets inside one counter's 8-word window
  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_CNT_LO    = 3'd1;
  localparam logic [2:0] OFF_CNT_HI    = 3'd2;
  localparam logic [2:0] OFF_SNAP_LO   = 3'd3;
  localparam logic [2:0] OFF_SNAP_HI   = 3'd4;
  localparam logic [2:0] OFF_STATUS    = 3'd5;
  localparam logic [2:0] OFF_THRESH_LO = 3'd6;
  localparam logic [2:0] OFF_THRESH_HI = 3'd7;

  localparam int unsigned GCTRL_FREEZE_BIT = 0;
  localparam int unsigned GCTRL_SNAP_BIT   = 1;

  typedef struct packed {
    logic [7:0] evt_sel;
    logic [3:0] src_sel;
    logic [1:0] rsvd;
    logic       clr_on_snap;
    logic       en;
  } ctrl_t;

  typedef struct packed {
    logic thr_hit;
    logic ovf;
  } status_t;

  // The global register sits directly after the last counter window
  function automatic int unsigned gctrl_word(input int unsigned num_counters);
    return num_counters * 8;
  endfunction

endpackage

// File: rtl/spatz_perf_counter_slice.sv
// One performance counter: value, snapshot, HI read shadow, sticky status and optional threshold.
// Threshold logic is present only when SPATZ_PERF_THRESHOLD_EN is defined.
module spatz_perf_counter_slice
  import spatz_perf_counter_pkg::*;
#(
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned IncWidth     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IncWidth-1:0]      inc_i,
  input  logic                     freeze_i,
  input  logic                     snap_i,
  input  logic [31:0]              wdata_i,
  input  logic                     ctrl_we_i,
  input  logic                     cnt_lo_we_i,
  input  logic                     cnt_hi_we_i,
  input  logic                     status_we_i,
  input  logic                     thresh_lo_we_i,
  input  logic                     thresh_hi_we_i,
  input  logic                     shadow_ld_i,
  output ctrl_t                    ctrl_o,
  output logic [CounterWidth-1:0]  cnt_o,
  output logic [CounterWidth-1:0]  snap_o,
  output logic [CounterWidth-33:0] shadow_o,
  output status_t                  status_o,
  output logic [CounterWidth-1:0]  thresh_o,
  output logic                     irq_req_o
);

  localparam int unsigned HiW = CounterWidth - 32;

  ctrl_t                   ctrl_q, ctrl_d;
  status_t                 status_q, status_d;
  logic [CounterWidth-1:0] cnt_q, cnt_d, snap_q, snap_d;
  logic [HiW-1:0]          shadow_q, shadow_d;
  logic [CounterWidth:0]   sum;
  logic                    bump, carry, thr_set;

`ifdef SPATZ_PERF_THRESHOLD_EN
  logic [CounterWidth-1:0] thresh_q, thresh_d;

  always_comb begin
    thresh_d = thresh_q;
    if (thresh_lo_we_i) thresh_d[31:0] = wdata_i;
    if (thresh_hi_we_i) thresh_d[CounterWidth-1:32] = wdata_i[HiW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) thresh_q <= '1;
    else       thresh_q <= thresh_d;
  end

  assign thr_set  = bump && (sum[CounterWidth-1:0] >= thresh_q);
  assign thresh_o = thresh_q;
`else
  logic unused_thresh_we;
  assign unused_thresh_we = thresh_lo_we_i ^ thresh_hi_we_i;
  assign thr_set  = 1'b0;
  assign thresh_o = '0;
`endif

  always_comb begin
    sum   = {1'b0, cnt_q} + (CounterWidth+1)'(inc_i);
    // A software write or a clearing snapshot takes the cycle; the increment is lost
    bump  = ctrl_q.en && !freeze_i && !cnt_lo_we_i && !cnt_hi_we_i
            && !(snap_i && ctrl_q.clr_on_snap);
    carry = bump && sum[CounterWidth];

    cnt_d = cnt_q;
    if (cnt_lo_we_i)                    cnt_d[31:0] = wdata_i;
    else if (cnt_hi_we_i)               cnt_d[CounterWidth-1:32] = wdata_i[HiW-1:0];
    else if (snap_i && ctrl_q.clr_on_snap) cnt_d = '0;
    else if (bump)                      cnt_d = sum[CounterWidth-1:0];

    snap_d   = snap_i ? cnt_q : snap_q;
    shadow_d = shadow_ld_i ? cnt_q[CounterWidth-1:32] : shadow_q;

    ctrl_d = ctrl_q;
    if (ctrl_we_i) begin
      ctrl_d      = ctrl_t'(wdata_i[15:0]);
      ctrl_d.rsvd = '0;
    end

    // Clear first, then set, so a simultaneous event wins over W1C
    status_d = status_q;
    if (status_we_i) begin
      status_d.ovf     = status_q.ovf     & ~wdata_i[0];
      status_d.thr_hit = status_q.thr_hit & ~wdata_i[1];
    end
    status_d.ovf     = status_d.ovf     | carry;
    status_d.thr_hit = status_d.thr_hit | thr_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      status_q <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      shadow_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      shadow_q <= shadow_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign cnt_o     = cnt_q;
  assign snap_o    = snap_q;
  assign shadow_o  = shadow_q;
  assign status_o  = status_q;
  assign irq_req_o = status_d.thr_hit & ctrl_d.en;

endmodule

// File: rtl/spatz_perf_counter_unit.sv
// Cluster performance counter unit: register decode, GCTRL, event selection and response register.
// Define SPATZ_PERF_THRESHOLD_EN to add THRESH registers and the threshold interrupt.
module spatz_perf_counter_unit
  import spatz_perf_counter_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned NumSources   = 4,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned IncWidth     = 8,
  parameter int unsigned AddrWidth    = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumSources*NumEvents*IncWidth-1:0] events_i,
  input  logic                                     snapshot_i,
  input  logic                                     cfg_req_valid_i,
  input  logic                                     cfg_req_write_i,
  input  logic [AddrWidth-1:0]                     cfg_req_addr_i,
  input  logic [31:0]                              cfg_req_wdata_i,
  output logic                                     cfg_req_ready_o,
  output logic                                     cfg_rsp_valid_o,
  output logic [31:0]                              cfg_rsp_rdata_o,
  output logic                                     cfg_rsp_error_o,
  output logic [NumCounters-1:0]                   overflow_o,
  output logic                                     irq_o
);

  localparam int unsigned IdxW = (NumCounters > 1) ? $clog2(NumCounters) : 1;
  localparam int unsigned SrcW = (NumSources  > 1) ? $clog2(NumSources)  : 1;
  localparam int unsigned EvtW = (NumEvents   > 1) ? $clog2(NumEvents)   : 1;
  localparam logic [AddrWidth-1:0] GctrlAddr = AddrWidth'(gctrl_word(NumCounters));

  logic [NumSources-1:0][NumEvents-1:0][IncWidth-1:0] events_q, events_d;
  logic        freeze_q, freeze_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [AddrWidth-4:0] idx;
  logic [IdxW-1:0]      cidx;
  logic [2:0]           off;
  logic                 wr, rd, hit_cnt, hit_gctrl, snap_trig, dec_err;
  logic [31:0]          rdata;

  ctrl_t   [NumCounters-1:0]                   ctrl;
  status_t [NumCounters-1:0]                   status;
  logic    [NumCounters-1:0][CounterWidth-1:0] cnt, snap, thresh;
  logic    [NumCounters-1:0][CounterWidth-33:0] shadow;
  logic    [NumCounters-1:0][IncWidth-1:0]     inc;
  logic    [NumCounters-1:0] ctrl_we, lo_we, hi_we, st_we, thl_we, thh_we, shadow_ld, irq_req;

  assign idx       = cfg_req_addr_i[AddrWidth-1:3];
  assign cidx      = idx[IdxW-1:0];
  assign off       = cfg_req_addr_i[2:0];
  assign wr        = cfg_req_valid_i && cfg_req_write_i;
  assign rd        = cfg_req_valid_i && !cfg_req_write_i;
  assign hit_cnt   = 32'(idx) < NumCounters;
  assign hit_gctrl = cfg_req_addr_i == GctrlAddr;
  assign snap_trig = (snapshot_i || (wr && hit_gctrl && cfg_req_wdata_i[GCTRL_SNAP_BIT])) && !freeze_q;

  always_comb begin
    ctrl_we = '0; lo_we = '0; hi_we = '0; st_we = '0; thl_we = '0; thh_we = '0; shadow_ld = '0;
    for (int n = 0; n < NumCounters; n++) begin
      if (hit_cnt && 32'(idx) == 32'(n)) begin
        ctrl_we[n]   = wr && off == OFF_CTRL;
        lo_we[n]     = wr && off == OFF_CNT_LO;
        hi_we[n]     = wr && off == OFF_CNT_HI;
        st_we[n]     = wr && off == OFF_STATUS;
        shadow_ld[n] = rd && off == OFF_CNT_LO;
`ifdef SPATZ_PERF_THRESHOLD_EN
        thl_we[n]    = wr && off == OFF_THRESH_LO;
        thh_we[n]    = wr && off == OFF_THRESH_HI;
`endif
      end
    end
  end

  // Unsupported source/event selections count nothing
  always_comb begin
    for (int n = 0; n < NumCounters; n++) begin
      inc[n] = '0;
      if (32'(ctrl[n].src_sel) < NumSources && 32'(ctrl[n].evt_sel) < NumEvents)
        inc[n] = events_q[ctrl[n].src_sel[SrcW-1:0]][ctrl[n].evt_sel[EvtW-1:0]];
    end
  end

  for (genvar n = 0; n < NumCounters; n++) begin : gen_slice
    spatz_perf_counter_slice #(
      .CounterWidth (CounterWidth),
      .IncWidth     (IncWidth)
    ) u_slice (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .inc_i          (inc[n]),
      .freeze_i       (freeze_q),
      .snap_i         (snap_trig),
      .wdata_i        (cfg_req_wdata_i),
      .ctrl_we_i      (ctrl_we[n]),
      .cnt_lo_we_i    (lo_we[n]),
      .cnt_hi_we_i    (hi_we[n]),
      .status_we_i    (st_we[n]),
      .thresh_lo_we_i (thl_we[n]),
      .thresh_hi_we_i (thh_we[n]),
      .shadow_ld_i    (shadow_ld[n]),
      .ctrl_o         (ctrl[n]),
      .cnt_o          (cnt[n]),
      .snap_o         (snap[n]),
      .shadow_o       (shadow[n]),
      .status_o       (status[n]),
      .thresh_o       (thresh[n]),
      .irq_req_o      (irq_req[n])
    );
  end

  // Reads see the state of the request cycle; the response register adds the one-cycle latency
  always_comb begin
    rdata   = '0;
    dec_err = 1'b0;
    if (hit_gctrl) begin
      rdata = {31'b0, freeze_q};
    end else if (hit_cnt) begin
      case (off)
        OFF_CTRL:    rdata = {16'b0, ctrl[cidx]};
        OFF_CNT_LO:  rdata = cnt[cidx][31:0];
        OFF_CNT_HI:  rdata = 32'(shadow[cidx]);
        OFF_SNAP_LO: begin rdata = snap[cidx][31:0];                     dec_err = cfg_req_write_i; end
        OFF_SNAP_HI: begin rdata = 32'(snap[cidx][CounterWidth-1:32]);   dec_err = cfg_req_write_i; end
        OFF_STATUS:  rdata = {30'b0, status[cidx]};
`ifdef SPATZ_PERF_THRESHOLD_EN
        OFF_THRESH_LO: rdata = thresh[cidx][31:0];
        OFF_THRESH_HI: rdata = 32'(thresh[cidx][CounterWidth-1:32]);
`endif
        default:     dec_err = 1'b1;
      endcase
    end else begin
      dec_err = 1'b1;
    end

    events_d    = events_i;
    freeze_d    = (wr && hit_gctrl) ? cfg_req_wdata_i[GCTRL_FREEZE_BIT] : freeze_q;
    rsp_valid_d = cfg_req_valid_i;
    rsp_error_d = cfg_req_valid_i && dec_err;
    rsp_rdata_d = (rd && !dec_err) ? rdata : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      events_q    <= '0;
      freeze_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      events_q    <= events_d;
      freeze_q    <= freeze_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef SPATZ_PERF_THRESHOLD_EN
  logic irq_q, irq_d;
  assign irq_d = |irq_req;
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq_o = irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^{irq_req, thresh};
  assign irq_o = 1'b0;
`endif

  always_comb begin
    for (int n = 0; n < NumCounters; n++) overflow_o[n] = status[n].ovf;
  end

  assign cfg_req_ready_o = 1'b1;
  assign cfg_rsp_valid_o = rsp_valid_q;
  assign cfg_rsp_rdata_o = rsp_rdata_q;
  assign cfg_rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_spatz_perf_counter_unit.sv
// Bench for spatz_perf_counter_unit (default build, threshold feature off): directed scenarios
// plus randomized register traffic, compared cycle by cycle with an arithmetic reference model.
module tb_spatz_perf_counter_unit;
  localparam int NC = 8, CW = 48, NS = 4, NE = 16, IW = 8, AW = 8;
  localparam int GADDR = NC * 8;
  localparam longint unsigned MOD = 64'd1 << CW;

  logic clk = 1'b0;
  logic rst;
  logic [NS-1:0][NE-1:0][IW-1:0] events;
  logic snapshot, req_valid, req_write, req_ready, rsp_valid, rsp_error, irq;
  logic [AW-1:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [NC-1:0] ovf;

  always #5 clk = ~clk;

  spatz_perf_counter_unit #(
    .NumCounters(NC), .CounterWidth(CW), .NumSources(NS),
    .NumEvents(NE), .IncWidth(IW), .AddrWidth(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .events_i(events), .snapshot_i(snapshot),
    .cfg_req_valid_i(req_valid), .cfg_req_write_i(req_write),
    .cfg_req_addr_i(req_addr), .cfg_req_wdata_i(req_wdata),
    .cfg_req_ready_o(req_ready), .cfg_rsp_valid_o(rsp_valid),
    .cfg_rsp_rdata_o(rsp_rdata), .cfg_rsp_error_o(rsp_error),
    .overflow_o(ovf), .irq_o(irq)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: counters as plain integers, wrap handled by modulo
  longint unsigned m_cnt[NC], m_snap[NC];
  int unsigned m_shadow[NC], m_ctrl[NC];
  bit m_ovf[NC];
  bit m_freeze;
  logic [NS-1:0][NE-1:0][IW-1:0] m_ev;

  function automatic void m_reset();
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = 0; m_snap[k] = 0; m_shadow[k] = 0; m_ctrl[k] = 0; m_ovf[k] = 0;
    end
    m_freeze = 0;
    m_ev = '0;
  endfunction

  function automatic void m_access(input bit w, input int a, output int unsigned rd, output bit err);
    int n = a / 8, o = a % 8;
    rd = 0; err = 0;
    if (a == GADDR) rd = m_freeze;
    else if (n < NC) begin
      case (o)
        0: rd = m_ctrl[n];
        1: rd = int'(m_cnt[n] % 64'h1_0000_0000);
        2: rd = m_shadow[n];
        3: begin rd = int'(m_snap[n] % 64'h1_0000_0000); err = w; end
        4: begin rd = int'(m_snap[n] / 64'h1_0000_0000); err = w; end
        5: rd = m_ovf[n];
        default: err = 1;
      endcase
    end else err = 1;
    if (w || err) rd = 0;
  endfunction

  function automatic void m_step(input bit r, input bit v, input bit w, input int a,
                                 input int unsigned d, input bit sn);
    int n = a / 8, o = a % 8;
    bit do_snap, wr_here, rd_here;
    if (r) begin m_reset(); return; end
    do_snap = !m_freeze && (sn || (v && w && a == GADDR && d[1]));
    for (int k = 0; k < NC; k++) begin
      int s = (m_ctrl[k] >> 4) & 15, e = (m_ctrl[k] >> 8) & 255;
      longint unsigned inc = (s < NS && e < NE) ? 64'(m_ev[s][e]) : 0;
      longint unsigned nv = m_cnt[k];
      bit carry = 0;
      wr_here = v && w && n == k;
      rd_here = v && !w && n == k;
      if (wr_here && o == 1) nv = (nv / 64'h1_0000_0000) * 64'h1_0000_0000 + d;
      else if (wr_here && o == 2) nv = nv % 64'h1_0000_0000 + ((64'(d) << 32) % MOD);
      else if (do_snap && m_ctrl[k][1]) nv = 0;
      else if (m_ctrl[k][0] && !m_freeze) begin
        nv = nv + inc;
        if (nv >= MOD) begin nv -= MOD; carry = 1; end
      end
      if (wr_here && o == 5 && d[0]) m_ovf[k] = 0;
      if (carry) m_ovf[k] = 1;
      if (do_snap) m_snap[k] = m_cnt[k];
      if (rd_here && o == 1) m_shadow[k] = int'(m_cnt[k] >> 32);
      if (wr_here && o == 0) m_ctrl[k] = d & 32'h0000_FFF3;
      m_cnt[k] = nv;
    end
    if (v && w && a == GADDR) m_freeze = d[0];
    m_ev = events;
  endfunction

  logic [31:0] last_rdata;
  logic last_err;

  task automatic cyc(input bit v, input bit w, input int a, input int unsigned d, input bit sn);
    int unsigned e_rd;
    bit e_err, e_vld;
    logic [NC-1:0] e_ovf;
    req_valid = v; req_write = w; req_addr = AW'(a); req_wdata = d; snapshot = sn;
    m_access(w, a, e_rd, e_err);
    e_vld = v && !rst;
    @(posedge clk);
    m_step(rst, v, w, a, d, sn);
    #1;
    chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, e_vld});
    if (e_vld) begin
      chk("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, e_rd});
      chk("rsp_error", {63'b0, rsp_error}, {63'b0, e_err});
    end
    for (int k = 0; k < NC; k++) e_ovf[k] = m_ovf[k];
    chk("overflow_o", 64'(ovf), 64'(e_ovf));
    chk("irq_o", {63'b0, irq}, 64'd0);
    last_rdata = rsp_rdata;
    last_err   = rsp_error;
    @(negedge clk);
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0); endtask
  task automatic rd_reg(input int a); cyc(1, 0, a, 0, 0); endtask
  task automatic wr_reg(input int a, input int unsigned d); cyc(1, 1, a, d, 0); endtask

  initial begin
    rst = 1; events = '0; snapshot = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    m_reset();
    @(negedge clk);
    idle(); idle();
    rst = 0;
    chk("ready", {63'b0, req_ready}, 64'd1);
    rd_reg(0);
    chk("reset_ctrl0", {32'b0, last_rdata}, 64'd0);

    // counter0: src 1, evt 3, increment 5 for 10 cycles
    wr_reg(0, (3 << 8) | (1 << 4) | 1);
    events[1][3] = 8'd5;
    repeat (10) idle();
    events[1][3] = 8'd0;
    idle();
    rd_reg(1);
    chk("count_50", {32'b0, last_rdata}, 64'd50);

    // carry out of 48 bits, sticky ovf, W1C
    wr_reg(1, 32'hFFFF_FFFE);
    wr_reg(2, 32'h0000_FFFF);
    events[1][3] = 8'd3;
    idle();
    events[1][3] = 8'd0;
    idle();
    rd_reg(1);
    chk("wrap_value", {32'b0, last_rdata}, 64'd1);
    rd_reg(5);
    chk("ovf_status", {32'b0, last_rdata}, 64'd1);
    chk("ovf_out", 64'(ovf[0]), 64'd1);
    wr_reg(5, 1);
    rd_reg(5);
    chk("ovf_cleared", {32'b0, last_rdata}, 64'd0);

    // atomic HI: shadow holds pre-carry upper bits
    wr_reg(1, 32'hFFFF_FFF0);
    wr_reg(2, 0);
    rd_reg(1);
    chk("lo_before", {32'b0, last_rdata}, 64'hFFFF_FFF0);
    events[1][3] = 8'h20;
    idle();
    events[1][3] = 8'd0;
    idle();
    rd_reg(2);
    chk("hi_shadow_old", {32'b0, last_rdata}, 64'd0);
    rd_reg(1);
    chk("lo_after", {32'b0, last_rdata}, 64'h10);
    rd_reg(2);
    chk("hi_shadow_new", {32'b0, last_rdata}, 64'd1);

    // counter2 clear-on-snapshot, then the same under freeze
    wr_reg(16, 3);
    events[0][0] = 8'd7;
    repeat (4) idle();
    events[0][0] = 8'd0;
    idle();
    cyc(0, 0, 0, 0, 1);
    rd_reg(19);
    chk("snap_old", {32'b0, last_rdata}, 64'd28);
    rd_reg(17);
    chk("cleared_cnt", {32'b0, last_rdata}, 64'd0);
    wr_reg(GADDR, 1);
    wr_reg(17, 123);
    events[0][0] = 8'd7;
    cyc(0, 0, 0, 0, 1);
    idle();
    events[0][0] = 8'd0;
    idle();
    rd_reg(19);
    chk("frozen_snap", {32'b0, last_rdata}, 64'd28);
    rd_reg(17);
    chk("frozen_cnt", {32'b0, last_rdata}, 64'd123);
    rd_reg(GADDR);
    chk("gctrl_freeze", {32'b0, last_rdata}, 64'd1);
    wr_reg(GADDR, 0);
    wr_reg(GADDR, 2);
    rd_reg(19);
    chk("gsnap_snap", {32'b0, last_rdata}, 64'd123);
    rd_reg(17);
    chk("gsnap_cnt", {32'b0, last_rdata}, 64'd0);

    // unmapped and read-only accesses
    rd_reg(GADDR + 1);
    chk("unmapped_err", {63'b0, last_err}, 64'd1);
    chk("unmapped_data", {32'b0, last_rdata}, 64'd0);
    wr_reg(19, 32'hDEAD);
    chk("ro_write_err", {63'b0, last_err}, 64'd1);
    rd_reg(19);
    chk("ro_unchanged", {32'b0, last_rdata}, 64'd123);
    rd_reg(6);
    chk("rsvd_err", {63'b0, last_err}, 64'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int a, o, r;
      int unsigned d;
      bit v, w;
      for (int s = 0; s < NS; s++)
        for (int e = 0; e < NE; e++)
          events[s][e] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
      rst = (i >= 700 && i < 702);
      r = $urandom_range(0, 99);
      v = r >= 40;
      w = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 99);
      if (r < 90) a = $urandom_range(0, NC - 1) * 8 + $urandom_range(0, 7);
      else if (r < 95) a = GADDR;
      else a = $urandom_range(0, 255);
      o = a % 8;
      d = $urandom;
      if (a == GADDR) d = ($urandom_range(0, 9) == 0 ? 1 : 0) | ($urandom_range(0, 1) << 1);
      else if (o == 0) begin
        int unsigned evt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, NE - 1);
        int unsigned src = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NS - 1);
        d = ($urandom & 32'hFFFF_000C) | (evt << 8) | (src << 4) | ($urandom_range(0, 1) << 1)
            | (($urandom_range(0, 3) != 0) ? 1 : 0);
      end else if (o == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FF00 | ($urandom & 32'hFF);
      else if (o == 2 && $urandom_range(0, 1) == 1) d = 32'h0000_FFFF;
      cyc(v, w, a, d, $urandom_range(0, 19) == 0);
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
